// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised UART receiver. The raw line passes through a two-flop
// synchroniser. A free-running divider produces an oversampling tick, and
// each bit is decided by a 2-of-3 majority vote of samples taken around the
// bit centre. Each received word is held behind a valid/ready handshake,
// together with its parity, framing and break status.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   rxd_in      in   asynchronous serial line, idle high
//   rx_data     out  received word; the first bit on the line lands in bit 0
//   rx_valid    out  rx_data and the status flags are valid; held until accepted
//   rx_ready    in   consumer accepts the word when rx_valid & rx_ready
//   parity_err  out  parity mismatch for the held word
//   frame_err   out  a stop bit was voted 0 for the held word
//   break_det   out  data, parity and stop bits were all voted 0
//   overrun     out  sticky: a frame was dropped because a word was still held
//   busy        out  receiver state machine is not idle
//   state_dbg   out  current FSM state, for debug and checkers
//
// Handshake: a word transfers on every clock edge where rx_valid and
// rx_ready are both 1. Once rx_valid is raised, rx_data and the flags stay
// stable until that transfer happens. rx_ready may be driven without regard
// to rx_valid.
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W  = $clog2(OVERSAMPLE);

    localparam logic [SAMP_W-1:0] SMP_FIRST = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SMP_MID   = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SMP_VOTE  = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMP_W-1:0] SMP_LAST  = SAMP_W'(OVERSAMPLE - 1);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PAR       = 3'd3,
        S_STOP      = 3'd4,
        S_DONE      = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  rxd_meta_q, rxd_meta_d;
    logic                  rxd_sync_q, rxd_sync_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [SAMP_W-1:0]     samp_cnt_q, samp_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  smp0_q, smp0_d;
    logic                  smp1_q, smp1_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  par_acc_q, par_acc_d;
    logic                  perr_acc_q, perr_acc_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic                  zero_acc_q, zero_acc_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  break_det_q, break_det_d;
    logic                  overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic rxd_s;
    logic tick;
    logic at_s0, at_s1, at_vote, at_end;
    logic vote;
    logic commit;
    logic accept;

    assign rxd_s   = rxd_sync_q;
    assign tick    = (div_cnt_q == DIV_W'(DIV - 1));
    assign at_s0   = tick && (samp_cnt_q == SMP_FIRST);
    assign at_s1   = tick && (samp_cnt_q == SMP_MID);
    assign at_vote = tick && (samp_cnt_q == SMP_VOTE);
    assign at_end  = tick && (samp_cnt_q == SMP_LAST);

    // The third sample is the live synchronised line, so the vote is ready
    // on the same tick that takes it.
    assign vote = (smp0_q & smp1_q) | (smp0_q & rxd_s) | (smp1_q & rxd_s);

    assign commit = (state_q == S_DONE);
    assign accept = rx_valid_q & rx_ready;

    // ------------------------------------------------------------------
    // State register (and all other flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            div_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            smp0_q       <= 1'b1;
            smp1_q       <= 1'b1;
            shreg_q      <= '0;
            par_acc_q    <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            zero_acc_q   <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rxd_meta_q   <= rxd_meta_d;
            rxd_sync_q   <= rxd_sync_d;
            div_cnt_q    <= div_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            smp0_q       <= smp0_d;
            smp1_q       <= smp1_d;
            shreg_q      <= shreg_d;
            par_acc_q    <= par_acc_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            zero_acc_q   <= zero_acc_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tick && !rxd_s) state_d = S_START;
            end
            S_START: begin
                // A start bit that votes 1 is noise: drop back immediately.
                if (at_vote && vote)  state_d = S_IDLE;
                else if (at_end)      state_d = S_DATA;
            end
            S_DATA: begin
                if (at_end && (bit_cnt_q == LAST_DATA))
                    state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (at_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Finish at the vote of the last stop bit rather than at its
                // end, so a start bit right behind it is not missed.
                if (at_vote && (bit_cnt_q == LAST_STOP)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = rxd_s ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (tick && rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        rxd_meta_d   = rxd_in;
        rxd_sync_d   = rxd_meta_q;
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        smp0_d       = smp0_q;
        smp1_d       = smp1_q;
        shreg_d      = shreg_q;
        par_acc_d    = par_acc_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        zero_acc_d   = zero_acc_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        overrun_d    = overrun_q;

        case (state_q)
            S_IDLE, S_DONE, S_WAIT_HIGH: begin
                // Keep the frame accumulators primed for the next start bit.
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
                par_acc_d  = 1'b0;
                perr_acc_d = 1'b0;
                ferr_acc_d = 1'b0;
                zero_acc_d = 1'b1;
            end
            default: begin
                // Wraps naturally at the bit boundary (OVERSAMPLE is 2^n).
                if (tick) samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                if (at_s0) smp0_d = rxd_s;
                if (at_s1) smp1_d = rxd_s;
            end
        endcase

        case (state_q)
            S_DATA: begin
                if (at_vote) begin
                    shreg_d    = {vote, shreg_q[DATA_BITS-1:1]};
                    par_acc_d  = par_acc_q ^ vote;
                    zero_acc_d = zero_acc_q & ~vote;
                end
                if (at_end)
                    bit_cnt_d = (bit_cnt_q == LAST_DATA) ? 4'd0 : bit_cnt_q + 4'd1;
            end
            S_PAR: begin
                if (at_vote) begin
                    // Even: total XOR must be 0. Odd: total XOR must be 1.
                    perr_acc_d = (PARITY == 2) ? ~(par_acc_q ^ vote)
                                               :  (par_acc_q ^ vote);
                    zero_acc_d = zero_acc_q & ~vote;
                end
            end
            S_STOP: begin
                if (at_vote) begin
                    if (!vote) ferr_acc_d = 1'b1;
                    zero_acc_d = zero_acc_q & ~vote;
                end
                if (at_end) bit_cnt_d = bit_cnt_q + 4'd1;
            end
            default: ;
        endcase

        // Handshake: a transfer clears the word and the sticky overrun flag.
        // A frame arriving while a word is still held and not being taken
        // is dropped.
        if (accept) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                parity_err_d = perr_acc_q;
                frame_err_d  = ferr_acc_q;
                break_det_d  = zero_acc_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != S_IDLE);
        state_dbg = state_q;
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
//
// Directed bench for uart_rx_param at 16 clk per bit (DIV = 1). Two
// instances: dut_a is 8N1, dut_p is 8E1. Each has its own line, and the
// instance that is not under test sees an idle-high line.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

  localparam int CLK_FREQ = 1843200;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // stimulus
  logic line  = 1'b1;
  logic sel_p = 1'b0;
  logic rdy   = 1'b0;
  logic rxd_a, rxd_p;
  assign rxd_a = sel_p ? 1'b1 : line;
  assign rxd_p = sel_p ? line : 1'b1;

  // dut_a outputs
  logic [7:0] a_data;
  logic       a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy;
  logic [2:0] a_state;
  // dut_p outputs
  logic [7:0] p_data;
  logic       p_valid, p_perr, p_ferr, p_brk, p_ovr, p_busy;
  logic [2:0] p_state;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .rxd_in(rxd_a),
    .rx_data(a_data), .rx_valid(a_valid), .rx_ready(rdy),
    .parity_err(a_perr), .frame_err(a_ferr), .break_det(a_brk),
    .overrun(a_ovr), .busy(a_busy), .state_dbg(a_state)
  );

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) dut_p (
    .clk(clk), .rst(rst), .rxd_in(rxd_p),
    .rx_data(p_data), .rx_valid(p_valid), .rx_ready(rdy),
    .parity_err(p_perr), .frame_err(p_ferr), .break_det(p_brk),
    .overrun(p_ovr), .busy(p_busy), .state_dbg(p_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: all driving happens 1 time unit after a rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    for (int j = 0; j < OS; j++) begin
      line = (glitch && j == OS / 2 + 1) ? ~b : b;
      cycles(1);
    end
    line = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                            input logic stop_bit, input logic [7:0] gmask);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i], gmask[i]);
    if (has_par) send_bit(par_bit, 1'b0);
    send_bit(stop_bit, 1'b0);
  endtask

  task automatic wait_valid_a(input string tag);
    int n;
    n = 0;
    while (!a_valid && n < 64) begin
      cycles(1);
      n++;
    end
    chk(tag, 32'(a_valid), 32'd1);
  endtask

  task automatic accept_one;
    rdy = 1'b1;
    cycles(1);
    rdy = 1'b0;
  endtask

  initial begin
    // reset
    cycles(4);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_data",  32'(a_data),  32'd0);
    chk("rst_flags", {28'd0, a_perr, a_ferr, a_brk, a_ovr}, 32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    rst = 1'b0;
    cycles(20);

    // 1: 8N1 0xA5, consumer stalls 50 clk
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00);
    wait_valid_a("t1_valid");
    chk("t1_data", 32'(a_data), 32'hA5);
    cycles(50);
    chk("t1_hold", 32'(a_valid), 32'd1);
    chk("t1_flags", {28'd0, a_perr, a_ferr, a_brk, a_ovr}, 32'd0);
    accept_one();
    chk("t1_cleared", 32'(a_valid), 32'd0);
    cycles(16);

    // 2: even parity on dut_p
    sel_p = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 8'h00);
    cycles(2);
    chk("t2a_valid", 32'(p_valid), 32'd1);
    chk("t2a_data",  32'(p_data),  32'h03);
    chk("t2a_perr",  32'(p_perr),  32'd1);
    accept_one();
    cycles(16);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 8'h00);
    cycles(2);
    chk("t2b_valid", 32'(p_valid), 32'd1);
    chk("t2b_perr",  32'(p_perr),  32'd0);
    chk("t2b_ferr",  32'(p_ferr),  32'd0);
    accept_one();
    sel_p = 1'b0;
    cycles(16);

    // 3: stop bit 0, then a clean frame
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 8'h00);
    cycles(16);
    wait_valid_a("t3_valid");
    chk("t3_data", 32'(a_data), 32'hC3);
    chk("t3_ferr", 32'(a_ferr), 32'd1);
    chk("t3_brk",  32'(a_brk),  32'd0);
    accept_one();
    cycles(16);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8'h00);
    wait_valid_a("t3b_valid");
    chk("t3b_data", 32'(a_data), 32'h5A);
    chk("t3b_ferr", 32'(a_ferr), 32'd0);
    accept_one();
    cycles(16);

    // 4: break of 20 bit times, consumer stalled throughout
    line = 1'b0;
    cycles(20 * OS);
    chk("t4_valid", 32'(a_valid), 32'd1);
    chk("t4_data",  32'(a_data),  32'h00);
    chk("t4_ferr",  32'(a_ferr),  32'd1);
    chk("t4_brk",   32'(a_brk),   32'd1);
    chk("t4_no_ovr", 32'(a_ovr),  32'd0);
    chk("t4_busy",  32'(a_busy),  32'd1);
    line = 1'b1;
    accept_one();
    cycles(5);
    chk("t4_idle", 32'(a_busy), 32'd0);
    cycles(40);
    chk("t4_no_more", 32'(a_valid), 32'd0);

    // 5: 4-clk start pulse, then centre-sample glitches on bits 2 and 5
    line = 1'b0;
    cycles(4);
    line = 1'b1;
    cycles(60);
    chk("t5_no_frame", 32'(a_valid), 32'd0);
    chk("t5_idle",     32'(a_busy),  32'd0);
    send_frame(8'h04, 1'b0, 1'b0, 1'b1, 8'h24);
    wait_valid_a("t5_valid");
    chk("t5_data", 32'(a_data), 32'h04);
    chk("t5_ferr", 32'(a_ferr), 32'd0);
    accept_one();
    cycles(16);

    // 6: overrun, then reset mid-frame with a word held
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 8'h00);
    cycles(16);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 8'h00);
    cycles(16);
    chk("t6_valid", 32'(a_valid), 32'd1);
    chk("t6_data",  32'(a_data),  32'h11);
    chk("t6_ovr",   32'(a_ovr),   32'd1);
    accept_one();
    chk("t6_acc_valid", 32'(a_valid), 32'd0);
    chk("t6_acc_ovr",   32'(a_ovr),   32'd0);
    cycles(16);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 8'h00);
    cycles(8);
    chk("t6_held", 32'(a_data), 32'h33);
    line = 1'b0;
    cycles(40);
    chk("t6_midframe_busy", 32'(a_busy), 32'd1);
    rst  = 1'b1;
    line = 1'b1;
    cycles(2);
    chk("t6_rst_valid", 32'(a_valid), 32'd0);
    chk("t6_rst_data",  32'(a_data),  32'd0);
    chk("t6_rst_busy",  32'(a_busy),  32'd0);
    chk("t6_rst_flags", {28'd0, a_perr, a_ferr, a_brk, a_ovr}, 32'd0);
    rst = 1'b0;
    cycles(20);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 8'h00);
    wait_valid_a("t6_7e_valid");
    chk("t6_7e_data",  32'(a_data), 32'h7E);
    chk("t6_7e_flags", {28'd0, a_perr, a_ferr, a_brk, a_ovr}, 32'd0);
    accept_one();
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver with configurable data width, parity and stop bits. Includes an internal oversampling tick generator, an input synchroniser, and majority-vote bit sampling. Flags parity, framing, break and overrun errors, and holds each received word behind a valid/ready handshake. Sits between the board RxD pin and consumer logic (command decoder or RX FIFO).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, ticks per bit; power of 2, minimum 4
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
rxd_in  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_valid  out  1  rx_data and status flags are valid; held until accepted
rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready
parity_err  out  1  parity mismatch for the held word
frame_err  out  1  a stop bit sampled 0 for the held word
break_det  out  1  whole frame 0, including parity and stop bits
overrun  out  1  sticky; at least one frame was dropped
busy  out  1  state machine is not IDLE

Behaviour:
- Reset: state IDLE; rx_data=0; rx_valid, parity_err, frame_err, break_det, overrun and busy all 0; tick counter and bit counters cleared. The synchroniser resets to 1. Reset asserted mid-frame abandons the frame and drops any held word.
- Synchroniser: 2 flip-flops on rxd_in. All logic below uses the synchronised signal.
- Tick: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, minimum 1. A counter pulses tick for one clk every DIV clks; it is free-running after reset.
- Majority vote: for each bit, samples are taken on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit period. The bit value is the 2-of-3 majority.
- States:
  - IDLE: on a tick with the line 0, go to START and clear the sample counter.
  - START: vote the start bit. A result of 1 is a false start; return to IDLE with no output. A result of 0 goes to DATA at the bit-period boundary.
  - DATA: vote DATA_BITS bits, shifting into the MSB so the first bit lands in bit 0. Then go to PAR if PARITY != 0, otherwise to STOP.
  - PAR: vote the parity bit. The error is (XOR of data bits XOR parity bit) != 0 for even, == 0 for odd.
  - STOP: vote STOP_BITS bits. Any 0 sets the frame error. Always proceed to DONE.
  - DONE (1 clk): commit the frame (see Handshake below). Then go to IDLE if the line is 1, otherwise to WAIT_HIGH.
  - WAIT_HIGH: stay until one tick samples the line at 1, then go to IDLE. This prevents a break from producing repeated frames.
- Latency: rx_valid rises 2 clk after the tick carrying the third vote sample of the last stop bit (one clk into DONE, one clk to commit).
- Handshake and commit:
  - If rx_valid=0 at commit, or rx_valid & rx_ready in the commit cycle: load rx_data, parity_err, frame_err and break_det, and set rx_valid=1.
  - If rx_valid=1 & rx_ready=0 at commit: discard the new frame, keep the old word and flags, and set overrun=1.
  - rx_valid & rx_ready with no commit in the same cycle clears rx_valid. The flags hold their values; they are only meaningful while rx_valid=1.
- overrun clears on the first accepted handshake after it was set.
- break_det: all data bits, the parity bit (if present) and every stop bit voted 0. Implies frame_err=1.
- busy=1 in every state except IDLE.

Test Plan:
(common setup: CLK_FREQ=1843200, BAUD=115200, OVERSAMPLE=16, so DIV=1 and 16 clk per bit)
1. 8N1, send 0xA5, rx_ready=0 for 50 clk and then 1 -> rx_data=0xA5; rx_valid held 1 until the accept, then 0; all error flags 0.
2. PARITY=1, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
3. 8N1, stop bit driven 0, then line high -> frame_err=1, break_det=0, rx_data correct. Next frame 0x5A is received cleanly.
4. Line held low for 20 bit times -> exactly one frame: rx_data=0x00, frame_err=1, break_det=1. No further frame until the line returns high.
5. Start pulse low for 4 clk; a separate data bit with a 1-clk glitch at the centre sample -> no frame from the short start; the glitched bit's vote rejects the glitch.
6. Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1; accept clears overrun. Apply rst mid-frame -> all outputs 0, busy=0, and the next frame 0x7E is received correctly.
